// File: rtl/msym_carry_sequencer.sv
// Time-shared carry resolver: turns signed redundant symbols into a binary word, LSB-first.
// Define MSYM_CARRY_SEQUENCER_OVF_EN to add the out_ovf result flag.
module msym_carry_sequencer #(
  parameter int NUMSYMBOLS   = 32,
  parameter int LOGRADIX     = 33,
  parameter int SYMSPERCYCLE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LOGRADIX:0]              in_symbols [NUMSYMBOLS],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUMSYMBOLS*LOGRADIX-1:0] out_data,
  output logic [1:0]                     out_carry,
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
  output logic                           out_ovf,
`endif
  output logic                           busy
);
  localparam int NBITS  = NUMSYMBOLS * LOGRADIX;
  localparam int NSTEPS = NUMSYMBOLS / SYMSPERCYCLE;
  localparam int SLICE  = SYMSPERCYCLE * LOGRADIX;
  localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  // Symbol plus carry lies in [-2^LOGRADIX-2, 2^LOGRADIX-1], so LOGRADIX+2 bits hold it exactly.
  localparam int TW     = LOGRADIX + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [LOGRADIX:0] sym_q [NUMSYMBOLS];
  logic [NBITS-1:0]  data_q;
  logic [NBITS-1:0]  digits;
  logic [1:0]        carry_q, carry_d, chain_c;
  logic [TW-1:0]     chain_t;
  logic [STEP_W-1:0] step_q;
  logic              last_step;

  assign last_step = (step_q == STEP_W'(NSTEPS - 1));

  // Resolve the lowest SYMSPERCYCLE held symbols; digits land at the top of the word and are
  // shifted down each step, so after NSTEPS steps every slice sits at its own weight.
  always_comb begin
    // NOTE: blocking assignments here are deliberate: each symbol must see the carry the
    // previous iteration produced within the same cycle.
    chain_c = carry_q;
    chain_t = '0;
    digits  = '0;
    for (int j = 0; j < SYMSPERCYCLE; j++) begin
      chain_t = {sym_q[j][LOGRADIX], sym_q[j]} + {{LOGRADIX{chain_c[1]}}, chain_c};
      digits[NBITS-SLICE+j*LOGRADIX +: LOGRADIX] = chain_t[LOGRADIX-1:0];
      chain_c = chain_t[LOGRADIX+1:LOGRADIX];
    end
    carry_d = chain_c;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last_step) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the symbol holding register carries no reset; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      sym_q <= in_symbols;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NUMSYMBOLS - SYMSPERCYCLE; i++) sym_q[i] <= sym_q[i + SYMSPERCYCLE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      carry_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          step_q  <= '0;
          carry_q <= '0;
        end
        RUN: begin
          step_q  <= step_q + STEP_W'(1);
          carry_q <= carry_d;
          data_q  <= (data_q >> SLICE) | digits;
        end
        default: ;
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign busy      = (state_q != IDLE);

`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
  // A final carry of -2 means the value does not fit NBITS+1-bit two's complement.
  assign out_ovf = (carry_q == 2'b10);
`endif

endmodule

// File: tb/tb_msym_carry_sequencer.sv
// Directed and randomised checks of msym_carry_sequencer across three parameterisations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_msym_carry_sequencer;
  localparam int CN  = 32;
  localparam int CL  = 33;
  localparam int CS  = 4;
  localparam int CNB = CN * CL;
  localparam int CW  = CNB + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_vec = 0;
  int n_bad = 0;

  // Instance a: 4 symbols of 8 bits, all resolved in one step.
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [8:0]  a_sym [4];
  logic [31:0] a_out_data;
  logic [1:0]  a_out_carry;
  // Instance b: 4 symbols of 8 bits, one per step.
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [8:0]  b_sym [4];
  logic [31:0] b_out_data;
  logic [1:0]  b_out_carry;
  // Instance c: default parameters.
  logic           c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [CL:0]    c_sym [CN];
  logic [CNB-1:0] c_out_data;
  logic [1:0]     c_out_carry;
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
  logic a_out_ovf, b_out_ovf, c_out_ovf;
`endif

  msym_carry_sequencer #(.NUMSYMBOLS(4), .LOGRADIX(8), .SYMSPERCYCLE(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_symbols(a_sym),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_carry(a_out_carry),
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
    .out_ovf(a_out_ovf),
`endif
    .busy(a_busy));

  msym_carry_sequencer #(.NUMSYMBOLS(4), .LOGRADIX(8), .SYMSPERCYCLE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_symbols(b_sym),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_carry(b_out_carry),
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
    .out_ovf(b_out_ovf),
`endif
    .busy(b_busy));

  msym_carry_sequencer #(.NUMSYMBOLS(CN), .LOGRADIX(CL), .SYMSPERCYCLE(CS)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_symbols(c_sym),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_carry(c_out_carry),
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
    .out_ovf(c_out_ovf),
`endif
    .busy(c_busy));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One job on instance a, starting at a falling edge where it is idle (cycle 0).
  task automatic job_a(input logic [8:0] s0, s1, s2, s3, input logic [31:0] exp_d,
                       input logic [1:0] exp_c, input logic exp_o, input int hold);
    a_sym[0] = s0; a_sym[1] = s1; a_sym[2] = s2; a_sym[3] = s3;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("a_c1_in_ready", a_in_ready, 0);
    check("a_c1_out_valid", a_out_valid, 0);
    check("a_c1_busy", a_busy, 1);
    @(negedge clk);
    check("a_c2_out_valid", a_out_valid, 1);
    check("a_out_data", a_out_data, exp_d);
    check("a_out_carry", a_out_carry, exp_c);
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
    check("a_out_ovf", a_out_ovf, exp_o);
`else
    if (exp_o === 1'bx) check("a_exp_ovf_known", exp_o, 0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("a_hold_data", a_out_data, exp_d);
      check("a_hold_in_ready", a_in_ready, 0);
      check("a_hold_out_valid", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    check("a_pop_in_ready", a_in_ready, 1);
    check("a_pop_out_valid", a_out_valid, 0);
    check("a_pop_busy", a_busy, 0);
  endtask

  logic [CW-1:0]  exp_sum, term;
  logic [CNB-1:0] exp_d;
  logic [1:0]     exp_c;
  logic           acc, popped, seen;
  int             mode;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin a_sym[i] = '0; b_sym[i] = '0; end
    for (int i = 0; i < CN; i++) c_sym[i] = '0;
    repeat (2) @(negedge clk);

    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_carry", a_out_carry, 0);
    check("rst_c_in_ready", c_in_ready, 1);
    check("rst_c_out_data_lo", c_out_data[63:0], 0);
    rst = 1'b0;

    // All zero.
    job_a(9'h000, 9'h000, 9'h000, 9'h000, 32'h0000_0000, 2'b00, 1'b0, 0);
    // -1 in symbol 0: borrow ripples through every digit.
    job_a(9'h1FF, 9'h000, 9'h000, 9'h000, 32'hFFFF_FFFF, 2'b11, 1'b0, 0);
    // All -256: carry reaches -2; out_data held for 10 stalled cycles.
    job_a(9'h100, 9'h100, 9'h100, 9'h100, 32'hFEFE_FF00, 2'b10, 1'b1, 10);

    // Instance b: sym0=-256, sym1..3=+255.
    // -256 + 255*(2^8+2^16+2^24) = 0xFFFFFF00 - 0x100 = 0xFFFFFE00, carry 0.
    b_sym[0] = 9'h100; b_sym[1] = 9'h0FF; b_sym[2] = 9'h0FF; b_sym[3] = 9'h0FF;
    b_in_valid = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      check($sformatf("b_c%0d_in_ready", cyc), b_in_ready, 0);
      check($sformatf("b_c%0d_out_valid", cyc), b_out_valid, 0);
    end
    @(negedge clk);
    check("b_c5_in_ready", b_in_ready, 0);
    check("b_c5_out_valid", b_out_valid, 1);
    check("b_out_data", b_out_data, 32'hFFFF_FE00);
    check("b_out_carry", b_out_carry, 2'b00);
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
    check("b_out_ovf", b_out_ovf, 0);
`endif
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_pop_in_ready", b_in_ready, 1);

    // Reset during the second RUN cycle abandons the job.
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("b_rst_in_ready", b_in_ready, 1);
    check("b_rst_out_valid", b_out_valid, 0);
    check("b_rst_busy", b_busy, 0);
    repeat (5) begin
      @(negedge clk);
      check("b_rst_no_emit", b_out_valid, 0);
    end
    for (int i = 0; i < 4; i++) b_sym[i] = '0;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b_zero_out_valid", b_out_valid, 1);
    check("b_zero_out_data", b_out_data, 0);
    check("b_zero_out_carry", b_out_carry, 0);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;

    // Default parameters: random jobs against a full-width sum model.
    for (int j = 0; j < 1000; j++) begin
      mode = $urandom_range(0, 5);
      for (int i = 0; i < CN; i++) begin
        if (mode == 0)      c_sym[i] = {1'b1, {CL{1'b0}}};
        else if (mode == 1) c_sym[i] = {1'b0, {CL{1'b1}}};
        else                c_sym[i] = (CL + 1)'({$urandom, $urandom});
      end
      exp_sum = '0;
      for (int i = 0; i < CN; i++) begin
        term    = {{(CW - CL - 1){c_sym[i][CL]}}, c_sym[i]};
        exp_sum = exp_sum + (term << (CL * i));
      end
      exp_d = exp_sum[CNB-1:0];
      exp_c = exp_sum[CNB+1:CNB];

      repeat ($urandom_range(0, 3)) @(negedge clk);
      c_in_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        acc = c_in_ready;
        @(negedge clk);
      end
      c_in_valid = 1'b0;
      check("c_accept", acc, 1);

      seen = 1'b0;
      popped = 1'b0;
      for (int k = 0; k < 200 && !popped; k++) begin
        if (c_out_valid && !seen) begin
          seen = 1'b1;
          for (int b = 0; b < CNB; b += 64)
            check($sformatf("c_data_bit%0d", b), 64'(c_out_data >> b), 64'(exp_d >> b));
          check("c_out_carry", c_out_carry, exp_c);
`ifdef MSYM_CARRY_SEQUENCER_OVF_EN
          check("c_out_ovf", c_out_ovf, exp_c == 2'b10);
`endif
        end
        c_out_ready = ($urandom_range(0, 2) != 0);
        popped = c_out_valid && c_out_ready;
        @(negedge clk);
      end
      c_out_ready = 1'b0;
      check("c_popped", popped, 1);
      check("c_idle_after_pop", c_in_ready, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
